// File: rtl/key_rx_ctrl.sv
// Serial key-code receiver: start qualify, mid-bit sampling, 6-nibble code assembly, compare and lockout.
// Optional even-parity bit before the stop bit is enabled by defining KEY_RX_PARITY_EN.
module key_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int NIBBLES      = 6,
    parameter int TIMEOUT_BITS = 64,
    parameter int MAX_FAIL     = 3,
    parameter int LOCK_CYCLES  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_bit_i,
    input  logic                       clear_i,
    input  logic [4*NIBBLES-1:0]       ref_code_i,
    output logic [3:0]                 nibble_o,
    output logic                       nibble_valid_o,
    output logic [4*NIBBLES-1:0]       code_o,
    output logic                       code_valid_o,
    output logic                       match_o,
    output logic                       mismatch_o,
    output logic                       frame_err_o,
    output logic                       timeout_o,
    output logic                       locked_o,
    output logic [$clog2(NIBBLES)-1:0] nib_cnt_o,
    output logic                       busy_o
);

    localparam int CODE_W     = 4 * NIBBLES;
    localparam int CNT_W      = $clog2(CLKS_PER_BIT);
    localparam int NC_W       = $clog2(NIBBLES);
    localparam int IDLE_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int IDLE_W     = $clog2(IDLE_LIMIT);
    localparam int LOCK_W     = $clog2(LOCK_CYCLES + 1);
    localparam int FAIL_W     = $clog2(MAX_FAIL + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_MID   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);
    localparam logic [NC_W-1:0]   NC_LAST   = NC_W'(NIBBLES - 1);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYCLES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef KEY_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;

    // Even parity: data bits plus parity bit must hold an even number of ones.
    function automatic logic even_par_err(input logic [3:0] data, input logic par_bit);
        return ^{data, par_bit};
    endfunction
`endif

    logic [1:0]        sync_q;
    logic              rx_s;
    logic              frame_ok_s;
    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        data_q, data_d;
    logic [CODE_W-1:0] buf_q, buf_d;
    logic [NC_W-1:0]   nib_cnt_q, nib_cnt_d;
    logic              done_q, done_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
    logic              locked_q, locked_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [3:0]        nibble_q, nibble_d;
    logic              nibble_valid_q, nibble_valid_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              code_valid_q, code_valid_d;
    logic              match_q, match_d;
    logic              mismatch_q, mismatch_d;
    logic              frame_err_q, frame_err_d;
    logic              timeout_q, timeout_d;
    logic              busy_q, busy_d;
`ifdef KEY_RX_PARITY_EN
    logic              par_err_q, par_err_d;
`endif

    assign rx_s = sync_q[1];

    // Two-flop synchronizer; resets to the idle (high) line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_bit_i};
        end
    end

    // Next-state logic for the receiver, code assembly, timeout and lockout.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        data_d         = data_q;
        buf_d          = buf_q;
        nib_cnt_d      = nib_cnt_q;
        done_d         = 1'b0;
        idle_cnt_d     = idle_cnt_q;
        fail_cnt_d     = fail_cnt_q;
        locked_d       = locked_q;
        lock_cnt_d     = lock_cnt_q;
        nibble_d       = nibble_q;
        nibble_valid_d = 1'b0;
        code_d         = code_q;
        code_valid_d   = 1'b0;
        match_d        = 1'b0;
        mismatch_d     = 1'b0;
        frame_err_d    = 1'b0;
        timeout_d      = 1'b0;
        frame_ok_s     = 1'b0;
`ifdef KEY_RX_PARITY_EN
        par_err_d      = par_err_q;
`endif

        // The lockout timer runs regardless of clear; locked stays high for LOCK_CYCLES clocks.
        if (locked_q) begin
            if (lock_cnt_q == LOCK_W'(1)) begin
                locked_d   = 1'b0;
                lock_cnt_d = '0;
            end else begin
                lock_cnt_d = lock_cnt_q - LOCK_W'(1);
            end
        end else begin
            lock_cnt_d = lock_cnt_q;
        end

        if (clear_i) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            idx_d      = 2'd0;
            buf_d      = '0;
            nib_cnt_d  = '0;
            idle_cnt_d = '0;
        end else begin
            // Code completes the cycle after the last nibble; while locked the code is dropped.
            if (done_q) begin
                buf_d = '0;
                if (!locked_q) begin
                    code_d       = buf_q;
                    code_valid_d = 1'b1;
                    if (buf_q == ref_code_i) begin
                        match_d    = 1'b1;
                        fail_cnt_d = '0;
                    end else begin
                        mismatch_d = 1'b1;
                        if (fail_cnt_q == FAIL_LAST) begin
                            fail_cnt_d = '0;
                            locked_d   = 1'b1;
                            lock_cnt_d = LOCK_LOAD;
                        end else begin
                            fail_cnt_d = fail_cnt_q + FAIL_W'(1);
                        end
                    end
                end else begin
                    code_d = code_q;
                end
            end else begin
                buf_d = buf_q;
            end

            if ((state_q == S_IDLE) && (nib_cnt_q != '0)) begin
                if (idle_cnt_q == IDLE_LAST) begin
                    timeout_d  = 1'b1;
                    buf_d      = '0;
                    nib_cnt_d  = '0;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end else begin
                idle_cnt_d = '0;
            end

            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_d = '0;
                        idx_d = 2'd0;
                        if (!rx_s) begin
                            state_d = S_DATA;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d         = '0;
                        data_d[idx_q] = rx_s;
                        if (idx_q == 2'd3) begin
`ifdef KEY_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef KEY_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        par_err_d = even_par_err(data_q, rx_s);
                        state_d   = S_STOP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
`ifdef KEY_RX_PARITY_EN
                        frame_ok_s = rx_s & ~par_err_q;
`else
                        frame_ok_s = rx_s;
`endif
                        if (frame_ok_s) begin
                            nibble_d       = data_q;
                            nibble_valid_d = 1'b1;
                            buf_d          = {buf_q[CODE_W-5:0], data_q};
                            if (nib_cnt_q == NC_LAST) begin
                                nib_cnt_d = '0;
                                done_d    = 1'b1;
                            end else begin
                                nib_cnt_d = nib_cnt_q + NC_W'(1);
                            end
                        end else begin
                            frame_err_d = 1'b1;
                            buf_d       = '0;
                            nib_cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            idx_q          <= 2'd0;
            data_q         <= 4'd0;
            buf_q          <= '0;
            nib_cnt_q      <= '0;
            done_q         <= 1'b0;
            idle_cnt_q     <= '0;
            fail_cnt_q     <= '0;
            locked_q       <= 1'b0;
            lock_cnt_q     <= '0;
            nibble_q       <= 4'd0;
            nibble_valid_q <= 1'b0;
            code_q         <= '0;
            code_valid_q   <= 1'b0;
            match_q        <= 1'b0;
            mismatch_q     <= 1'b0;
            frame_err_q    <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
`ifdef KEY_RX_PARITY_EN
            par_err_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            data_q         <= data_d;
            buf_q          <= buf_d;
            nib_cnt_q      <= nib_cnt_d;
            done_q         <= done_d;
            idle_cnt_q     <= idle_cnt_d;
            fail_cnt_q     <= fail_cnt_d;
            locked_q       <= locked_d;
            lock_cnt_q     <= lock_cnt_d;
            nibble_q       <= nibble_d;
            nibble_valid_q <= nibble_valid_d;
            code_q         <= code_d;
            code_valid_q   <= code_valid_d;
            match_q        <= match_d;
            mismatch_q     <= mismatch_d;
            frame_err_q    <= frame_err_d;
            timeout_q      <= timeout_d;
            busy_q         <= busy_d;
`ifdef KEY_RX_PARITY_EN
            par_err_q      <= par_err_d;
`endif
        end
    end

    assign nibble_o       = nibble_q;
    assign nibble_valid_o = nibble_valid_q;
    assign code_o         = code_q;
    assign code_valid_o   = code_valid_q;
    assign match_o        = match_q;
    assign mismatch_o     = mismatch_q;
    assign frame_err_o    = frame_err_q;
    assign timeout_o      = timeout_q;
    assign locked_o       = locked_q;
    assign nib_cnt_o      = nib_cnt_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_key_rx_ctrl.sv
// Directed bench for key_rx_ctrl: reset, framing, code compare, glitch, frame error, lockout, timeout, clear.
// Parity vectors are added when KEY_RX_PARITY_EN is defined.
module tb_key_rx_ctrl;

    logic        clk;
    logic        rst;
    logic        rx_bit;
    logic        clear;
    logic [23:0] ref_code;
    logic [3:0]  nibble;
    logic        nibble_valid;
    logic [23:0] code;
    logic        code_valid;
    logic        match;
    logic        mismatch;
    logic        frame_err;
    logic        timeout;
    logic        locked;
    logic [2:0]  nib_cnt;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    int cyc = 0, nv_cnt = 0, cv_cnt = 0, m_cnt = 0, mm_cnt = 0, fe_cnt = 0, to_cnt = 0;
    int nv_cyc = 0, cv_cyc = 0, lock_cycles = 0;
    int nv0, fe0;

    key_rx_ctrl dut (
        .clk(clk), .rst(rst), .rx_bit_i(rx_bit), .clear_i(clear), .ref_code_i(ref_code),
        .nibble_o(nibble), .nibble_valid_o(nibble_valid), .code_o(code), .code_valid_o(code_valid),
        .match_o(match), .mismatch_o(mismatch), .frame_err_o(frame_err), .timeout_o(timeout),
        .locked_o(locked), .nib_cnt_o(nib_cnt), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (nibble_valid) begin nv_cnt <= nv_cnt + 1; nv_cyc <= cyc; end
        if (code_valid)   begin cv_cnt <= cv_cnt + 1; cv_cyc <= cyc; end
        if (match)     m_cnt  <= m_cnt + 1;
        if (mismatch)  mm_cnt <= mm_cnt + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (timeout)   to_cnt <= to_cnt + 1;
        if (locked)    lock_cycles <= lock_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx_bit = v;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input logic [3:0] nib, input logic stop_v);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(nib[i]);
`ifdef KEY_RX_PARITY_EN
        drive_bit(^nib);
`endif
        drive_bit(stop_v);
        rx_bit = 1'b1;
        repeat (8) @(negedge clk);
    endtask

`ifdef KEY_RX_PARITY_EN
    task automatic send_frame_par(input logic [3:0] nib, input logic par_v);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(nib[i]);
        drive_bit(par_v);
        drive_bit(1'b1);
        rx_bit = 1'b1;
        repeat (8) @(negedge clk);
    endtask
`endif

    task automatic send_code(input logic [23:0] c);
        for (int n = 5; n >= 0; n--) send_frame(c[4*n +: 4], 1'b1);
    endtask

    initial begin
        rst = 1'b1; rx_bit = 1'b1; clear = 1'b0; ref_code = 24'h123456;
        repeat (3) @(negedge clk);
        check("rst_nibble", {28'd0, nibble}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Reset in the middle of a frame.
        rx_bit = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_frame_busy", {31'd0, busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outs", {nibble, nib_cnt, busy, locked, code_valid, nibble_valid, frame_err},
              32'h0);
        check("rst_mid_code", {8'd0, code}, 32'h0);
        rx_bit = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        send_frame(4'hA, 1'b1);
        check("nib_A", {28'd0, nibble}, 32'hA);
        check("nib_A_count", nv_cnt, 32'd1);
        check("nib_A_cnt", {29'd0, nib_cnt}, 32'd1);

        // clear in the middle of DATA drops the frame and the partial code.
        nv0 = nv_cnt; fe0 = fe_cnt;
        drive_bit(1'b0);
        rx_bit = 1'b1;
        repeat (8) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_busy", {31'd0, busy}, 32'h0);
        check("clear_nib_cnt", {29'd0, nib_cnt}, 32'd0);
        repeat (80) @(negedge clk);
        check("clear_no_nv", nv_cnt, nv0);
        check("clear_no_fe", fe_cnt, fe0);

        // Full code that matches.
        send_code(24'h123456);
        check("code_val", {8'd0, code}, 32'h123456);
        check("code_valid_cnt", cv_cnt, 32'd1);
        check("match_cnt", m_cnt, 32'd1);
        check("mismatch_cnt0", mm_cnt, 32'd0);
        check("cv_after_nv", cv_cyc - nv_cyc, 32'd1);
        check("code_nib_cnt", {29'd0, nib_cnt}, 32'd0);

        // Short start glitch: back to idle, no pulses.
        nv0 = nv_cnt; fe0 = fe_cnt;
        rx_bit = 1'b0;
        repeat (4) @(negedge clk);
        rx_bit = 1'b1;
        repeat (16) @(negedge clk);
        check("glitch_busy", {31'd0, busy}, 32'h0);
        repeat (100) @(negedge clk);
        check("glitch_no_nv", nv_cnt, nv0);
        check("glitch_no_fe", fe_cnt, fe0);

        // Bad stop bit on the third nibble.
        send_frame(4'h1, 1'b1);
        send_frame(4'h2, 1'b1);
        check("pre_fe_cnt", {29'd0, nib_cnt}, 32'd2);
        send_frame(4'h3, 1'b0);
        check("fe_count", fe_cnt, fe0 + 1);
        check("fe_nib_cnt", {29'd0, nib_cnt}, 32'd0);
        check("fe_nv", nv_cnt, nv0 + 2);

        // Three mismatches lock; a correct code while locked is dropped.
        send_code(24'h000000);
        send_code(24'h000000);
        check("lock_not_yet", {31'd0, locked}, 32'h0);
        send_code(24'h000000);
        check("mismatch_cnt3", mm_cnt, 32'd3);
        check("locked_high", {31'd0, locked}, 32'h1);
        check("cv_after_mm", cv_cnt, 32'd4);
        nv0 = nv_cnt;
        send_code(24'h123456);
        check("locked_drop_cv", cv_cnt, 32'd4);
        check("locked_code_kept", {8'd0, code}, 32'h0);
        check("locked_nv_runs", nv_cnt, nv0 + 6);
        for (int i = 0; i < 3000 && locked; i++) @(negedge clk);
        check("unlocked", {31'd0, locked}, 32'h0);
        check("lock_cycles", lock_cycles, 32'd1024);
        send_code(24'h123456);
        check("post_lock_match", m_cnt, 32'd2);
        check("post_lock_code", {8'd0, code}, 32'h123456);

        // Idle timeout on a partial code.
        send_frame(4'h9, 1'b1);
        send_frame(4'h8, 1'b1);
        check("to_pre_cnt", {29'd0, nib_cnt}, 32'd2);
        repeat (1000) @(negedge clk);
        check("to_not_yet", to_cnt, 32'd0);
        repeat (40) @(negedge clk);
        check("to_pulse", to_cnt, 32'd1);
        check("to_nib_cnt", {29'd0, nib_cnt}, 32'd0);

`ifdef KEY_RX_PARITY_EN
        fe0 = fe_cnt; nv0 = nv_cnt;
        send_frame_par(4'h7, 1'b0);
        check("par_bad_fe", fe_cnt, fe0 + 1);
        check("par_bad_nv", nv_cnt, nv0);
        send_frame_par(4'h7, 1'b1);
        check("par_good_nv", nv_cnt, nv0 + 1);
        check("par_good_nib", {28'd0, nibble}, 32'h7);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_rx_ctrl.md
Name: key_rx_ctrl

Overview:
Controller that sequences the 4-bit serial key-code link: start-bit qualify, bit timing, LSB-first sampling and stop-bit check.
Assembles 6 nibbles into a 24-bit key code and compares each complete code against a reference code.
Enforces a lockout after repeated mismatches.
Sits between the keypad serial line and the access/compare logic; replaces free-running per-clock sampling with timed, validated sampling.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit period (even, >=4)
NIBBLES, 6, nibbles per key code (code width = 4*NIBBLES = 24)
TIMEOUT_BITS, 64, idle bit periods after which a partial code is discarded
MAX_FAIL, 3, consecutive mismatches that trigger lockout
LOCK_CYCLES, 1024, lockout duration in clk cycles

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
rx_bit  in  1  serial line, idle high, start bit low, 4 data bits LSB first, stop bit high
clear  in  1  sync abort: drop current frame and partial code
ref_code  in  24  reference key code, sampled on code completion
nibble  out  4  last received nibble
nibble_valid  out  1  1-cycle pulse, good nibble received
code  out  24  last completed code, oldest nibble in [23:20]
code_valid  out  1  1-cycle pulse, new code on code
match  out  1  1-cycle pulse with code_valid when code==ref_code
mismatch  out  1  1-cycle pulse with code_valid when code!=ref_code
frame_err  out  1  1-cycle pulse, bad stop (or parity) bit
timeout  out  1  1-cycle pulse, partial code discarded on idle
locked  out  1  lockout active
nib_cnt  out  3  nibbles held in partial buffer (0..NIBBLES-1)
busy  out  1  high while state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, bit/idle/lock/fail counters 0, partial buffer 0.
- Bit counter cnt runs 0..CLKS_PER_BIT-1 inside a frame.
- IDLE: rx_bit==0 -> START, cnt=0.
- START: at cnt==CLKS_PER_BIT/2-1, resample.
  - low -> DATA, cnt=0, bit index 0.
  - high -> IDLE silently; glitch, no error.
- DATA: sample at each cnt==CLKS_PER_BIT-1 into bit[idx]; after idx 3 -> STOP. Samples therefore fall at mid-bit.
- STOP: sample at cnt==CLKS_PER_BIT-1, then go to IDLE.
  - high: nibble updated, nibble_valid pulse, buffer={buf[19:0],nib}, nib_cnt+1.
  - low: frame_err pulse, nibble discarded, buffer and nib_cnt cleared.
- Code completion: when the 6th nibble is accepted, on the next cycle:
  - code<=buffer, code_valid pulse, match/mismatch pulse (compare uses ref_code in that cycle).
  - nib_cnt=0, buffer cleared.
- Fail counting:
  - match clears fail_cnt.
  - mismatch increments fail_cnt; reaching MAX_FAIL sets locked, fail_cnt=0, lock counter loads LOCK_CYCLES.
- Locked:
  - Receiver keeps running; nibble_valid and frame_err still pulse.
  - Completed codes are dropped: no code update, code_valid, match or mismatch.
  - locked deasserts after exactly LOCK_CYCLES cycles.
- Timeout:
  - Idle counter counts while state==IDLE and nib_cnt>0; resets on leaving IDLE.
  - At TIMEOUT_BITS*CLKS_PER_BIT cycles: timeout pulse, buffer/nib_cnt cleared.
- clear: highest priority after rst; state->IDLE, buffer/nib_cnt/cnt cleared, no pulses; does not affect fail_cnt or locked.
- A frame error or timeout on a partial code does not count as a failure.
- rx_bit is double-flop synchronized inside the block; all timings are from the synchronized signal (+2 cycles latency).

Optional Feature:
KEY_RX_PARITY_EN:
- Defined: an even-parity bit follows the 4 data bits (extra PARITY state, one bit period) before STOP.
  - Parity mismatch -> frame_err pulse, same discard rules as a bad stop bit; the stop bit is still checked.
- Undefined: no parity state; frame is start+4 data+stop.

Test Plan:
- Reset mid-frame (rst during DATA) -> all outputs 0, next clean frame of nibble 0xA -> nibble=0xA, nibble_valid once, nib_cnt=1.
- Six frames 1,2,3,4,5,6 with ref_code=0x123456 -> code=0x123456, code_valid+match one cycle after 6th nibble_valid, nib_cnt=0.
- Start glitch of 4 cycles low (CLKS_PER_BIT=16) -> no state beyond START, no pulses. Stop bit forced low on 3rd nibble -> frame_err, nib_cnt=0.
- Three codes 0x000000 vs ref 0x123456 -> three mismatch pulses, locked high for exactly 1024 cycles. A correct code sent during lock -> no code_valid. The same code after lock -> match.
- Two nibbles then idle 64*16 cycles -> timeout pulse, nib_cnt=0. clear asserted mid-DATA -> IDLE, no nibble_valid.
- With KEY_RX_PARITY_EN, nibble 0x7 with parity 0 -> frame_err. With parity 1 -> nibble_valid, nibble=0x7.
